// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt datapath.
// Imported by prga_decrypt.
package rc4_pkg;

  localparam int BYTE_W      = 8;
  localparam int MSG_LEN_DEF = 32;

  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    RD_SI,
    CAP_SI,
    RD_SJ,
    CAP_SJ,
    WR_SI,
    WR_SJ,
    RD_F,
    WAIT_F,
    CAP_F,
    WR_OUT,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA decrypt engine: walks S memory, XORs the keystream with
// the encrypted ROM and writes plaintext to the output RAM.
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] s_address,
  output logic [BYTE_W-1:0] s_data,
  output logic              s_wren,
  input  logic [BYTE_W-1:0] s_q,
  output logic [4:0]        rom_address,
  input  logic [BYTE_W-1:0] rom_q,
  output logic [4:0]        out_address,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_wren
);

  localparam int KW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(MSG_LEN - 1);

  state_t            r_state;
  logic [BYTE_W-1:0] r_i;
  logic [BYTE_W-1:0] r_j;
  logic [BYTE_W-1:0] r_si;
  logic [BYTE_W-1:0] r_sj;
  logic [BYTE_W-1:0] r_f;
  logic [BYTE_W-1:0] r_enc;
  logic [KW-1:0]     r_k;
  logic              r_hold;
  logic              r_busy;
  logic              r_done;
  logic [BYTE_W-1:0] r_s_address;
  logic [BYTE_W-1:0] r_s_data;
  logic              r_s_wren;
  logic [4:0]        r_rom_address;
  logic [4:0]        r_out_address;
  logic [BYTE_W-1:0] r_out_data;
  logic              r_out_wren;

  assign busy        = r_busy;
  assign done        = r_done;
  assign s_address   = r_s_address;
  assign s_data      = r_s_data;
  assign s_wren      = r_s_wren;
  assign rom_address = r_rom_address;
  assign out_address = r_out_address;
  assign out_data    = r_out_data;
  assign out_wren    = r_out_wren;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_si          <= '0;
      r_sj          <= '0;
      r_f           <= '0;
      r_enc         <= '0;
      r_k           <= '0;
      r_hold        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_s_address   <= '0;
      r_s_data      <= '0;
      r_s_wren      <= 1'b0;
      r_rom_address <= '0;
      r_out_address <= '0;
      r_out_data    <= '0;
      r_out_wren    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= INC_I;
          end
        end
        INC_I: begin
          r_i         <= r_i + 8'd1;
          r_s_address <= r_i + 8'd1;
          r_state     <= RD_SI;
        end
        RD_SI: r_state <= CAP_SI;
        CAP_SI: begin
          r_si        <= s_q;
          r_j         <= r_j + s_q;
          r_s_address <= r_j + s_q;
          r_state     <= RD_SJ;
        end
        RD_SJ: r_state <= CAP_SJ;
        CAP_SJ: begin
          r_sj    <= s_q;
          r_state <= WR_SI;
        end
        // when i==j both writes hit one address; the second restores S[i]
        WR_SI: begin
          r_s_address <= r_i;
          r_s_data    <= r_sj;
          r_s_wren    <= SWAP_EN;
          r_state     <= WR_SJ;
        end
        WR_SJ: begin
          r_s_address <= r_j;
          r_s_data    <= r_si;
          r_s_wren    <= SWAP_EN;
          r_state     <= RD_F;
        end
        RD_F: begin
          r_s_wren      <= 1'b0;
          r_s_address   <= r_si + r_sj;
          r_rom_address <= 5'(r_k);
          r_state       <= WAIT_F;
        end
        WAIT_F: r_state <= CAP_F;
        CAP_F: begin
          r_f     <= s_q;
          r_enc   <= rom_q;
          r_state <= WR_OUT;
        end
        WR_OUT: begin
          r_out_address <= 5'(r_k);
          r_out_data    <= r_f ^ r_enc;
          r_out_wren    <= 1'b1;
          r_state       <= NEXT;
        end
        // NEXT lasts two cycles so every byte costs 13 cycles
        NEXT: begin
          r_out_wren <= 1'b0;
          if (!r_hold) begin
            r_hold <= 1'b1;
          end else begin
            r_hold <= 1'b0;
            if (r_k == K_LAST) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= INC_I;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Randomised bench for prga_decrypt against an RC4 PRGA reference
// model; the bench also owns the S, ROM and output memories.
module tb_prga_decrypt;

  localparam int ML = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [7:0] s_address, s_data, s_q;
  logic       s_wren;
  logic [4:0] rom_address, out_address;
  logic [7:0] rom_q, out_data;
  logic       out_wren;

  prga_decrypt dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done),
    .s_address(s_address), .s_data(s_data),
    .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .out_address(out_address), .out_data(out_data),
    .out_wren(out_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] smem [256];
  logic [7:0] rom [ML];
  logic [7:0] omem [ML];
  int mS [256];
  logic [7:0] exp_out [ML];

  int n_chk = 0, n_err = 0;
  int s_wr = 0, o_wr = 0, ord_err = 0;
  int both_err = 0, idle_err = 0;
  int exp_addr = 0;

  always @(posedge clk) begin
    s_q   <= smem[s_address];
    rom_q <= rom[rom_address];
    if (s_wren) begin
      smem[s_address] = s_data;
      s_wr++;
    end
    if (out_wren) begin
      if (int'(out_address) != exp_addr) ord_err++;
      omem[out_address] = out_data;
      exp_addr++;
      o_wr++;
    end
    if (s_wren && out_wren) both_err++;
    if ((s_wren || out_wren) && !busy) idle_err++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RC4 PRGA from i=j=0 on mS, nbytes keystream bytes XORed with rom
  task automatic model(input int nbytes);
    int i = 0, j = 0, t;
    for (int k = 0; k < nbytes; k++) begin
      i = (i + 1) % 256;
      j = (j + mS[i]) % 256;
      t = mS[i]; mS[i] = mS[j]; mS[j] = t;
      exp_out[k] = 8'(mS[(mS[i] + mS[j]) % 256]) ^ rom[k];
    end
  endtask

  task automatic load_s(input bit ident);
    int r, t;
    for (int n = 0; n < 256; n++) mS[n] = n;
    if (!ident)
      for (int n = 255; n > 0; n--) begin
        r = $urandom_range(n, 0);
        t = mS[n]; mS[n] = mS[r]; mS[r] = t;
      end
    for (int n = 0; n < 256; n++) smem[n] = 8'(mS[n]);
  endtask

  task automatic cmp_s(input string tag);
    int bad = 0;
    for (int n = 0; n < 256; n++)
      if (int'(smem[n]) != mS[n]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // returns once busy is seen (the INC_I entry cycle) or bound expires
  task automatic wait_busy(output bit ok);
    int b = 0;
    while (!busy && b < 8) begin @(negedge clk); b++; end
    ok = busy;
    check("busy_rise", busy, 1);
  endtask

  task automatic run(input bit ident_chk, input bit poke);
    int n = 0, s0, o0, e0;
    bit ok;
    model(ML);
    s0 = s_wr; o0 = o_wr; e0 = ord_err; exp_addr = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_busy(ok);
    if (!ok) return;
    check("done_clr", done, 0);
    while (!done && n < 1000) begin
      @(negedge clk); n++;
      if (ident_chk && n == 12) check("s1_same", smem[1], 1);
      if (ident_chk && n == 39) begin
        check("s2", smem[2], 3);
        check("s3", smem[3], 5);
        check("s5", smem[5], 2);
      end
      if (poke && n == 50) start = 1'b1;
      if (poke && n == 51) start = 1'b0;
    end
    check("cycles", n, 13 * ML);
    check("busy_end", busy, 0);
    check("n_out_wr", o_wr - o0, ML);
    check("n_s_wr", s_wr - s0, 2 * ML);
    check("addr_order", ord_err - e0, 0);
    for (int k = 0; k < ML; k++) check("out", omem[k], exp_out[k]);
    cmp_s("smem");
  endtask

  initial begin
    int s0, o0;
    bit ok;
    for (int k = 0; k < ML; k++) rom[k] = 8'h00;
    load_s(1'b1);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_swren", s_wren, 0);
    check("rst_owren", out_wren, 0);
    check("rst_saddr", s_address, 0);
    check("rst_sdata", s_data, 0);
    check("rst_rom", rom_address, 0);
    check("rst_oaddr", out_address, 0);
    check("rst_odata", out_data, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(1'b1, 1'b0);
    check("out0", omem[0], 8'h02);
    check("out1", omem[1], 8'h05);
    check("out2", omem[2], 8'h07);

    load_s(1'b1);
    rom[0] = 8'h41; rom[1] = 8'h42; rom[2] = 8'h43;
    for (int k = 3; k < ML; k++) rom[k] = 8'($urandom);
    run(1'b0, 1'b1);
    check("v30_0", omem[0], 8'h43);
    check("v30_1", omem[1], 8'h47);
    check("v30_2", omem[2], 8'h44);

    for (int r = 0; r < 3; r++) begin
      load_s(1'b0);
      for (int k = 0; k < ML; k++) rom[k] = 8'($urandom);
      run(1'b0, r[0]);
    end

    // abort during WR_SI of byte 5, then rerun from i=j=k=0
    load_s(1'b0);
    for (int k = 0; k < ML; k++) rom[k] = 8'($urandom);
    s0 = s_wr; o0 = o_wr; exp_addr = 0;
    pulse_start();
    wait_busy(ok);
    if (ok) begin
      repeat (70) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_swren", s_wren, 0);
      check("abort_owren", out_wren, 0);
      check("abort_saddr", s_address, 0);
      repeat (20) @(negedge clk);
      check("abort_s_wr", s_wr - s0, 10);
      check("abort_o_wr", o_wr - o0, 5);
      model(5);
      for (int k = 0; k < 5; k++) check("abort_out", omem[k], exp_out[k]);
      cmp_s("abort_smem");
      run(1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("both_wren", both_err, 0);
    check("idle_write", idle_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
